// File: rtl/reg_alu_sequencer.sv
// Instruction sequencer and 8-bit ALU driving the single-port 16x8 register unit.
// Each instruction reads up to two sources, computes, writes back and reports flags.
module reg_alu_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               rf_load,
  output logic [ADDR_W-1:0]  rf_addr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic [DATA_W-1:0]  result,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               done,
  output logic               illegal
);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;
  localparam logic [3:0] OP_MOV = 4'd10;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

  state_t             state;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W:0]    alu_wide;
  logic [3:0]         new_op;
  logic [3:0]         op_q;
  logic [ADDR_W-1:0]  rd_q;
  logic [ADDR_W-1:0]  rs_q;
  logic [ADDR_W-1:0]  rt_q;
  logic               new_is_alu;

  assign new_op = instr[15:12];
  assign op_q   = instr_q[15:12];
  assign rd_q   = instr_q[8 +: ADDR_W];
  assign rs_q   = instr_q[4 +: ADDR_W];
  assign rt_q   = instr_q[0 +: ADDR_W];

  assign new_is_alu  = ((new_op >= OP_ADD) && (new_op <= OP_SHR)) || (new_op == OP_MOV);
  assign instr_ready = (state == IDLE) && !reset;

  // Bit DATA_W of the wide result is the carry, borrow or shifted-out bit.
  always_comb begin
    alu_wide = '0;
    case (op_q)
      OP_ADD:  alu_wide = {1'b0, op_a} + {1'b0, rf_rdata};
      OP_SUB:  alu_wide = {1'b0, op_a} - {1'b0, rf_rdata};
      OP_AND:  alu_wide = {1'b0, op_a & rf_rdata};
      OP_OR:   alu_wide = {1'b0, op_a | rf_rdata};
      OP_XOR:  alu_wide = {1'b0, op_a ^ rf_rdata};
      OP_NOT:  alu_wide = {1'b0, ~op_a};
      OP_SHL:  alu_wide = {op_a, 1'b0};
      OP_SHR:  alu_wide = {op_a[0], 1'b0, op_a[DATA_W-1:1]};
      OP_MOV:  alu_wide = {1'b0, op_a};
      default: alu_wide = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      instr_q    <= '0;
      op_a       <= '0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            if (new_is_alu) begin
              state <= RD_A;
            end else if (new_op == OP_LDI) begin
              result     <= instr[DATA_W-1:0];
              zero_flag  <= (instr[DATA_W-1:0] == '0);
              carry_flag <= 1'b0;
              state      <= WB;
            end else begin
              done    <= 1'b1;
              illegal <= (new_op > OP_MOV);
            end
          end
        end
        RD_A: state <= RD_B;
        RD_B: begin
          op_a  <= rf_rdata;
          state <= EXEC;
        end
        EXEC: begin
          result     <= alu_wide[DATA_W-1:0];
          zero_flag  <= (alu_wide[DATA_W-1:0] == '0);
          carry_flag <= alu_wide[DATA_W];
          state      <= WB;
        end
        WB: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port drive is decoded from state so reset drops rf_load without waiting for a clock.
  always_comb begin
    rf_load  = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    case (state)
      RD_A: rf_addr = rs_q;
      RD_B: rf_addr = rt_q;
      WB: begin
        rf_load  = 1'b1;
        rf_addr  = rd_q;
        rf_wdata = result;
      end
      default: begin
        rf_load  = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Bench for reg_alu_sequencer: emulates the register unit and checks every instruction
// against an arithmetic reference model of registers, result and flags.
module tb_reg_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        rf_load;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wdata;
  logic [7:0]  rf_rdata = 8'h00;
  logic [7:0]  result;
  logic        zero_flag;
  logic        carry_flag;
  logic        done;
  logic        illegal;

  logic [7:0] mem [16] = '{default: 8'h00};
  int         ref_regs [16];
  int         exp_result;
  int         exp_zero;
  int         exp_carry;
  int         wr_count = 0;
  int         last_waddr = 0;
  int         last_wdata = 0;
  int         checks = 0;
  int         errors = 0;

  reg_alu_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .rf_load    (rf_load),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .rf_rdata   (rf_rdata),
    .result     (result),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .done       (done),
    .illegal    (illegal)
  );

  always #5 clock = ~clock;

  // Register unit: one-cycle read latency, write visible to the next sampled address.
  always @(posedge clock) begin
    rf_rdata <= mem[rf_addr];
    if (rf_load) mem[rf_addr] <= rf_wdata;
  end

  always @(posedge clock) begin
    if (rf_load) begin
      wr_count   = wr_count + 1;
      last_waddr = int'(rf_addr);
      last_wdata = int'(rf_wdata);
    end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int op, input int rd, input int rs, input int rt, input int imm);
    int  a, b, res, c, lat, wr0, cyc;
    bit  writes, got;
    a = ref_regs[rs];
    b = ref_regs[rt];
    res = 0;
    c = 0;
    writes = 1'b1;
    lat = 5;
    case (op)
      1:  begin res = a + b; c = (res > 255) ? 1 : 0; res = res % 256; end
      2:  begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  res = 255 - a;
      7:  begin res = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      8:  begin res = a / 2; c = a % 2; end
      9:  begin res = imm; lat = 2; end
      10: res = a;
      default: begin writes = 1'b0; lat = 1; end
    endcase
    checkOutput("ready_idle", int'(instr_ready), 1);
    wr0 = wr_count;
    instr = (op == 9) ? {op[3:0], rd[3:0], imm[7:0]} : {op[3:0], rd[3:0], rs[3:0], rt[3:0]};
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clock);
      cyc = cyc + 1;
      if (done) got = 1'b1;
      else if (cyc < lat) checkOutput("ready_busy", int'(instr_ready), 0);
    end
    checkOutput("latency", got ? cyc : 99, lat);
    if (writes) begin
      ref_regs[rd] = res;
      exp_result = res;
      exp_zero = (res == 0) ? 1 : 0;
      exp_carry = c;
    end
    checkOutput("write_count", wr_count - wr0, writes ? 1 : 0);
    if (writes) begin
      checkOutput("wb_addr", last_waddr, rd);
      checkOutput("wb_data", last_wdata, res);
    end
    checkOutput("result", int'(result), exp_result);
    checkOutput("zero_flag", int'(zero_flag), exp_zero);
    checkOutput("carry_flag", int'(carry_flag), exp_carry);
    checkOutput("illegal", int'(illegal), (op > 10) ? 1 : 0);
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < 16; i++) ref_regs[i] = 0;
    exp_result = 0;
    exp_zero = 0;
    exp_carry = 0;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    #1;
    checkOutput("reset_ready", int'(instr_ready), 0);
    checkOutput("reset_load", int'(rf_load), 0);
    checkOutput("reset_result", int'(result), 0);
    checkOutput("reset_done", int'(done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;

    applyStimulus(9, 1, 0, 0, 8'h05);
    applyStimulus(9, 2, 0, 0, 8'h03);
    applyStimulus(9, 1, 0, 0, 8'hF0);
    applyStimulus(9, 2, 0, 0, 8'h20);
    applyStimulus(1, 3, 1, 2, 0);
    applyStimulus(9, 1, 0, 0, 8'h05);
    applyStimulus(9, 2, 0, 0, 8'h03);
    applyStimulus(2, 4, 2, 1, 0);
    applyStimulus(2, 5, 1, 1, 0);
    applyStimulus(9, 1, 0, 0, 8'h81);
    applyStimulus(7, 6, 1, 9, 0);
    applyStimulus(10, 7, 6, 3, 0);
    applyStimulus(12, 7, 6, 3, 0);
    applyStimulus(0, 7, 6, 3, 0);
    applyStimulus(8, 8, 1, 0, 0);
    applyStimulus(3, 9, 1, 4, 0);
    applyStimulus(5, 1, 1, 4, 0);

    // Abort an ADD while it is in EXEC.
    checkOutput("ready_idle", int'(instr_ready), 1);
    instr = 16'h1312;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    wr0 = wr_count;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("abort_load", int'(rf_load), 0);
    checkOutput("abort_ready", int'(instr_ready), 0);
    checkOutput("abort_result", int'(result), 0);
    checkOutput("abort_zero", int'(zero_flag), 0);
    checkOutput("abort_carry", int'(carry_flag), 0);
    checkOutput("abort_done", int'(done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("abort_no_write", wr_count - wr0, 0);
    checkOutput("abort_ready_after", int'(instr_ready), 1);
    exp_result = 0;
    exp_zero = 0;
    exp_carry = 0;

    for (int n = 0; n < 40; n++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 16; i++) checkOutput("regfile", int'(mem[i]), ref_regs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
